// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - frame accumulator for per-pair dot-product beats
// Sums a programmed number of 6-bit beats with saturation and tracks the frame maximum.
module dot_accumulator #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_dot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [5:0]       out_max,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [5:0]       max_q, max_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  // One extra bit catches the carry-out that signals saturation.
  logic [ACC_W:0]   sum_ext;
  logic [LEN_W-1:0] count_inc;

  assign sum_ext   = {1'b0, sum_q} + {{(ACC_W-5){1'b0}}, in_dot};
  assign count_inc = count_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    max_d   = max_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = frame_len;
          sum_d   = '0;
          max_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (frame_len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (sum_ext[ACC_W]) begin
            sum_d = '1;
            ovf_d = 1'b1;
          end else begin
            sum_d = sum_ext[ACC_W-1:0];
          end
          if (in_dot > max_q) max_d = in_dot;
          if (in_dot > 6'd32) err_d = 1'b1;
          count_d = count_inc;
          if (count_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_max   = max_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - directed bench for dot_accumulator
// Default-size instance plus a narrow ACC_W=7/LEN_W=4 instance for saturation.
module tb_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_b;
  logic [7:0]  frame_len;
  logic [3:0]  frame_len_b;
  logic        in_valid;
  logic [5:0]  in_dot;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf, out_err, busy;
  logic [13:0] out_sum;
  logic [5:0]  out_max;
  logic [7:0]  out_count;

  logic        in_ready_b, out_valid_b, out_ovf_b, out_err_b, busy_b;
  logic [6:0]  out_sum_b;
  logic [5:0]  out_max_b;
  logic [3:0]  out_count_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dot_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_dot(in_dot),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_count(out_count), .out_ovf(out_ovf),
    .out_err(out_err), .busy(busy)
  );

  dot_accumulator #(.LEN_W(4), .ACC_W(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .frame_len(frame_len_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_dot(in_dot),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_max(out_max_b), .out_count(out_count_b), .out_ovf(out_ovf_b),
    .out_err(out_err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats [4];
    int bv [6];
    int bd [6];
    int sb [5];

    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; frame_len = '0; frame_len_b = '0;
    in_valid = 1'b0; in_dot = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_max_cnt_flags", {out_max, out_count, out_ovf, out_err}, 0);
    rst_n = 1'b1;
    step();

    // reset mid-ACC after 2 of 4 beats
    start = 1'b1; frame_len = 8'd4;
    step();
    start = 1'b0;
    chk("midrst_acc_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_dot = 6'd5; step();
    in_dot = 6'd6; step();
    chk("midrst_partial_sum", 32'(out_sum), 11);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_sum", 32'(out_sum), 0);
    chk("midrst_count_busy", {out_count, busy, out_valid}, 0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; frame_len = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_dot = 6'd7;
    step();
    in_valid = 1'b0;
    chk("midrst_new_valid", 32'(out_valid), 1);
    chk("midrst_new_sum", 32'(out_sum), 7);
    out_ready = 1'b1;
    step();
    chk("midrst_new_idle", 32'(out_valid), 0);

    // basic frame
    beats = '{32, 0, 17, 5};
    start = 1'b1; frame_len = 8'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dot = 6'(beats[i]);
      chk("basic_in_ready", 32'(in_ready), 1);
      chk("basic_no_early_valid", 32'(out_valid), 0);
      step();
    end
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_in_ready_off", 32'(in_ready), 0);
    chk("basic_sum", 32'(out_sum), 54);
    chk("basic_max", 32'(out_max), 32);
    chk("basic_count", 32'(out_count), 4);
    chk("basic_ovf_err", {out_ovf, out_err}, 0);
    step();
    chk("basic_idle_valid", 32'(out_valid), 0);
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_idle_hold_sum", 32'(out_sum), 54);

    // input bubbles and output stall
    out_ready = 1'b0;
    bv = '{1, 0, 0, 1, 0, 1};
    bd = '{10, 63, 63, 20, 63, 30};
    start = 1'b1; frame_len = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = bv[i][0]; in_dot = 6'(bd[i]);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sum", 32'(out_sum), 60);
      start = (i == 2); frame_len = 8'd9;
      step();
      start = 1'b0;
    end
    chk("stall_max", 32'(out_max), 30);
    chk("stall_count", 32'(out_count), 3);
    chk("stall_err", 32'(out_err), 0);
    out_ready = 1'b1;
    step();
    chk("stall_start_ignored_busy", 32'(busy), 0);
    chk("stall_start_ignored_sum", 32'(out_sum), 60);

    // empty frame
    start = 1'b1; frame_len = 8'd0;
    step();
    start = 1'b0;
    chk("empty_valid", 32'(out_valid), 1);
    chk("empty_in_ready", 32'(in_ready), 0);
    chk("empty_results", {out_sum, out_max, out_count, out_ovf, out_err}, 0);
    step();
    chk("empty_idle", {out_valid, in_ready, busy}, 0);

    // back-to-back frames
    start = 1'b1; frame_len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_dot = 6'd1; step();
    in_dot = 6'd2; step();
    in_valid = 1'b0;
    chk("b2b_1_valid", 32'(out_valid), 1);
    chk("b2b_1_sum", 32'(out_sum), 3);
    step();
    start = 1'b1; frame_len = 8'd2;
    step();
    start = 1'b0;
    chk("b2b_2_ready", 32'(in_ready), 1);
    chk("b2b_2_cleared", {out_sum, out_count}, 0);
    in_valid = 1'b1; in_dot = 6'd3; step();
    in_dot = 6'd4; step();
    in_valid = 1'b0;
    chk("b2b_2_valid", 32'(out_valid), 1);
    chk("b2b_2_sum", 32'(out_sum), 7);
    chk("b2b_2_max", 32'(out_max), 4);
    chk("b2b_2_flags", {out_ovf, out_err}, 0);
    step();

    // saturation and error on narrow instance
    sb = '{32, 32, 32, 40, 1};
    start_b = 1'b1; frame_len_b = 4'd5;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_dot = 6'(sb[i]);
      chk("sat_in_ready", 32'(in_ready_b), 1);
      step();
    end
    in_valid = 1'b0;
    chk("sat_valid", 32'(out_valid_b), 1);
    chk("sat_sum", 32'(out_sum_b), 127);
    chk("sat_ovf", 32'(out_ovf_b), 1);
    chk("sat_err", 32'(out_err_b), 1);
    chk("sat_max", 32'(out_max_b), 40);
    chk("sat_count", 32'(out_count_b), 5);
    chk("sat_main_untouched", 32'(busy), 0);
    step();
    chk("sat_idle", 32'(out_valid_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Downstream stage of the dot-product unit. Consumes the stream of 6-bit per-pair dot-product results (each 0..32) over a valid/ready handshake. Sums a programmed number of them into one frame total, tracks the per-frame maximum, and presents the result on a valid/ready output port. It turns the single-cycle combinational inner product into a multi-word inner product over vectors of `frame_len`×32 bits.

## Interface
- `LEN_W`, default 8: width of frame length and beat counter; a frame holds up to 2^LEN_W−1 beats.
- `ACC_W`, default 14: accumulator width; must be ≥ 6+LEN_W for overflow-free operation.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `frame_len`  in  LEN_W  number of beats in the frame; latched on accepted `start`.
- `in_valid`  in  1  `in_dot` holds a beat.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_dot`  in  6  dot-product result beat.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  frame sum.
- `out_max`  out  6  largest `in_dot` accepted in the frame.
- `out_count`  out  LEN_W  beats accepted in the frame.
- `out_ovf`  out  1  sum saturated during the frame.
- `out_err`  out  1  at least one beat had `in_dot` > 32.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ACC, DONE. Two-bit state register; unused encodings go to IDLE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - On `start`=1: latch `frame_len`, clear sum/max/count/ovf/err.
  - Next state is ACC if `frame_len`≠0, else DONE (empty frame, all results 0).
- ACC:
  - `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`.
  - On accept: sum += zero-extended `in_dot`; count += 1; max = max(max, `in_dot`).
  - If `in_dot` > 32, set err sticky. The value is still accumulated as given.
  - When the accepted beat makes count == latched length, go to DONE.
  - Cycles without `in_valid` leave all state unchanged.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - `out_sum`/`out_max`/`out_count`/`out_ovf`/`out_err` stay stable until handshake.
  - On `out_valid`&&`out_ready`: go to IDLE.
  - Outputs keep their values in IDLE until the next accepted `start` clears them.
- `start` is ignored in ACC and DONE. `frame_len` changes after latch have no effect.
- Arithmetic:
  - The sum is unsigned and saturating. If sum + `in_dot` ≥ 2^ACC_W, sum becomes 2^ACC_W−1 and `out_ovf` sets sticky.
  - Max comparison is unsigned 6-bit.
- `in_ready` and `out_valid` are decoded from registered state only. They never depend combinationally on `in_valid`/`out_ready`.

## Timing
- Reset (async assert, released synchronously with `clk` by the system):
  - State goes to IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `out_sum`=0, `out_max`=0, `out_count`=0, `out_ovf`=0, `out_err`=0.
- Reset mid-frame discards the frame entirely; no partial result is presented.
- `start` sampled at edge T gives ACC (`in_ready`=1, `busy`=1) from T+1.
- Throughput: one beat per cycle in ACC. An N-beat frame with continuous `in_valid` has `in_ready` high for exactly N cycles.
- Last beat accepted at edge T gives `out_valid`=1 from T+1 with the final sum included; no extra pipeline latency.
- Empty frame: `start` at T gives `out_valid`=1 at T+1.
- Result handshake at edge T gives IDLE at T+1. A `start` at T is ignored. The earliest next `start` is sampled at T+1.
- Minimum frame period: N+2 cycles (start, N beats, result), plus output stall cycles.

## Test plan
- Reset mid-ACC after 2 of 4 beats:
  - Stimulus: assert `rst_n`=0.
  - Required: outputs 0 and `in_ready`=0 immediately.
  - Then a new frame of len 1 with beat 7 gives `out_sum`=7.
- Basic frame:
  - Stimulus: len=4; beats 32,0,17,5 back-to-back; `out_ready`=1.
  - Required: `out_valid` one cycle after beat 4; `out_sum`=54, `out_max`=32, `out_count`=4, ovf=0, err=0.
  - Then IDLE the next cycle.
- Input bubbles and output stall:
  - Stimulus: len=3; `in_valid` toggled 1,0,0,1,0,1; `out_ready` held 0 for 5 cycles.
  - Required: sum of the three beats held stable with `out_valid`=1 for all 5 cycles.
  - A `start` pulse during the stall is ignored.
- Empty frame:
  - Stimulus: `start` with len=0.
  - Required: `out_valid` the next cycle; all results 0; `in_ready` never asserts.
- Saturation and error:
  - Stimulus: instantiate ACC_W=7, LEN_W=4; len=5, beats 32,32,32,40,1.
  - Required: `out_sum`=127, `out_ovf`=1, `out_err`=1, `out_max`=40, `out_count`=5.
- Back-to-back frames:
  - Stimulus: `start` asserted one cycle after the result handshake; len=2 with beats 1,2, then len=2 with beats 3,4.
  - Required: results 3 then 7. The second frame shows no carry-over of max/ovf/err.
